pilha_rpn_param: RTL and testbench
==================================

PILHA_RPN_PARAM -- requirements
Module: pilha_rpn_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/data width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 8, stack capacity in words (>=2).
REQ-003 SHALL have ports, in order:
  clk  in  1  sole clock; all state changes on rising edge.
  rst  in  1  reset, synchronous, active-low.
  cmd_valid  in  1  command present.
  cmd_ready  out  1  block can accept a command.
  cmd  in  3  command code (see REQ-008).
  entrada  in  WIDTH  value pushed by PUSH.
  operacao  in  3  ALU operation code, sampled with EXEC.
  alu_a  out  WIDTH  ALU operand A (top of stack).
  alu_b  out  WIDTH  ALU operand B (second of stack).
  alu_op  out  3  registered ALU operation code.
  alu_result  in  WIDTH  ALU result, valid one cycle after EXEC acceptance.
  alu_erro  in  1  ALU error flag, same timing as alu_result.
  display_a  out  WIDTH  top word; 0 when empty.
  display_b  out  WIDTH  second word; 0 when count<2.
  contagem  out  $clog2(DEPTH+1)  words held.
  pilha_vazia  out  1  contagem==0.
  pilha_cheia  out  1  contagem==DEPTH.
  erro  out  1  sticky error flag.
  erro_cod  out  2  code of first error since last clear.
REQ-004 Reset SHALL be synchronous and active-low; port names clk and rst.

Function
REQ-005 Command SHALL be accepted on a rising edge where cmd_valid=1, cmd_ready=1, rst=1.
REQ-006 cmd_ready SHALL be 1 in state IDLE and 0 in state EXEC.
REQ-007 FSM SHALL have states IDLE and EXEC; accepted legal EXEC: IDLE->EXEC; EXEC->IDLE unconditionally next cycle.
REQ-008 Codes: 000 NOP, 001 PUSH, 010 POP, 011 EXEC, 100 DUP, 101 SWAP, 110 CLEAR, 111 illegal.
REQ-009 PUSH: store entrada at new top, contagem+1; if full: no change, error OVF.
REQ-010 POP: discard top, contagem-1; if empty: no change, error UNF.
REQ-011 EXEC with contagem>=2: register operacao into alu_op, hold alu_a=top, alu_b=second through EXEC state; else no state change, stay IDLE, error UNF.
REQ-012 In EXEC cycle, alu_erro=0: pop both operands, push alu_result (contagem-1, result becomes top), remaining words unchanged.
REQ-013 In EXEC cycle, alu_erro=1: stack unchanged, error ALU.
REQ-014 DUP: copy top to new top; empty -> UNF; full -> OVF; no change in either case.
REQ-015 SWAP: exchange top and second; contagem<2 -> UNF, no change.
REQ-016 CLEAR: contagem=0, erro=0, erro_cod=00; storage contents need not be zeroed.
REQ-017 Illegal code 111: no stack change, error ILL.
REQ-018 erro_cod: 00 OVF, 01 UNF, 10 ALU, 11 ILL; first error latched, later errors do not overwrite until CLEAR or reset.
REQ-019 alu_a/alu_b SHALL equal display_a/display_b at all times.
REQ-020 Status outputs SHALL reflect registered state (update one cycle after the accepting edge); no combinational path from cmd to status.
REQ-021 Arithmetic on contagem SHALL never wrap; guarded by REQ-009..REQ-015.

Reset
REQ-022 With rst=0 at an edge: contagem=0, state IDLE, alu_op=0, erro=0, erro_cod=00, displays 0, pilha_vazia=1, pilha_cheia=0.
REQ-023 Reset during EXEC SHALL abort the operation; alu_result discarded.
REQ-024 Commands SHALL be ignored in any cycle with rst=0.

Structure
REQ-025 Shared package pilha_rpn_pkg SHALL hold command codes, error codes, FSM state type.
REQ-026 Storage SHALL be sub-module pilha_mem (DEPTH x WIDTH register file, sync write, async read of top two).
REQ-027 ALU SHALL remain external; this block contains no arithmetic beyond contagem.

Verification (WIDTH=8, DEPTH=4)
REQ-028 PUSH 5, PUSH 3, EXEC op=add with alu_result=8 -> contagem 1, display_a=8, cmd_ready low exactly one cycle.
REQ-029 PUSH 1,2,3,4 then PUSH 9 -> pilha_cheia=1, contagem 4, display_a=4, erro=1, erro_cod=00.
REQ-030 From reset, POP then PUSH 7 then EXEC -> erro_cod=01 held, contagem 1, display_a=7.
REQ-031 PUSH 10, PUSH 20, SWAP, DUP -> contagem 3, display_a=10, display_b=10; POP -> display_b=20.
REQ-032 PUSH 2, PUSH 0, EXEC with alu_erro=1 -> contagem 2, display_a=0, display_b=2, erro_cod=10; CLEAR -> erro=0, pilha_vazia=1.
REQ-033 rst=0 asserted during EXEC cycle -> all outputs at REQ-022 values next cycle; cmd 111 afterwards -> erro_cod=11.

Source files
------------

// File: rtl/pilha_rpn_pkg.sv
// Shared definitions for the RPN stack: command codes, error codes, FSM states.
package pilha_rpn_pkg;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'b000,
    CMD_PUSH  = 3'b001,
    CMD_POP   = 3'b010,
    CMD_EXEC  = 3'b011,
    CMD_DUP   = 3'b100,
    CMD_SWAP  = 3'b101,
    CMD_CLEAR = 3'b110,
    CMD_ILL   = 3'b111
  } cmd_t;

  typedef enum logic [1:0] {
    ERR_OVF = 2'b00,
    ERR_UNF = 2'b01,
    ERR_ALU = 2'b10,
    ERR_ILL = 2'b11
  } err_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/pilha_mem.sv
// Stack storage: DEPTH x WIDTH register file, two synchronous write ports
// (SWAP needs both in one cycle) and asynchronous reads of the top two words.
module pilha_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             i_we0,
  input  logic [AW-1:0]    i_addr0,
  input  logic [WIDTH-1:0] i_data0,
  input  logic             i_we1,
  input  logic [AW-1:0]    i_addr1,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [AW-1:0]    i_raddr_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write ports; the controller never targets the same word on both.
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_addr0] <= i_data0;
    if (i_we1) r_mem[i_addr1] <= i_data1;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/pilha_rpn_param.sv
// RPN stack controller: holds operands for an external ALU, writes its
// result back, and tracks a sticky first-error code.
module pilha_rpn_param
  import pilha_rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd,
  input  logic [WIDTH-1:0]             entrada,
  input  logic [2:0]                   operacao,
  output logic [WIDTH-1:0]             alu_a,
  output logic [WIDTH-1:0]             alu_b,
  output logic [2:0]                   alu_op,
  input  logic [WIDTH-1:0]             alu_result,
  input  logic                         alu_erro,
  output logic [WIDTH-1:0]             display_a,
  output logic [WIDTH-1:0]             display_b,
  output logic [$clog2(DEPTH+1)-1:0]   contagem,
  output logic                         pilha_vazia,
  output logic                         pilha_cheia,
  output logic                         erro,
  output logic [1:0]                   erro_cod
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [2:0]       r_alu_op;
  logic             r_erro;
  logic [1:0]       r_erro_cod;

  logic             w_accept, w_empty, w_full, w_has2;
  logic             w_err_set, w_clear, w_load_op;
  err_t             w_err_code;
  logic             w_we0, w_we1;
  logic [AW-1:0]    w_addr0, w_addr1;
  logic [WIDTH-1:0] w_data0, w_data1;
  logic [AW-1:0]    w_top_idx, w_sec_idx, w_new_idx;
  logic [WIDTH-1:0] w_rd_top, w_rd_sec, w_disp_a, w_disp_b;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_has2   = (r_count >= CW'(2));
  assign w_accept = rst && cmd_valid && (r_state == ST_IDLE);

  // Word 0 is the bottom; top sits at count-1. Indices are pinned to 0 when
  // the slot does not exist so the read never leaves the array.
  assign w_top_idx = w_empty ? '0 : AW'(r_count - CW'(1));
  assign w_sec_idx = w_has2  ? AW'(r_count - CW'(2)) : '0;
  assign w_new_idx = w_full  ? '0 : AW'(r_count);

  pilha_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .i_we0     (w_we0),
    .i_addr0   (w_addr0),
    .i_data0   (w_data0),
    .i_we1     (w_we1),
    .i_addr1   (w_addr1),
    .i_data1   (w_data1),
    .i_raddr_a (w_top_idx),
    .i_raddr_b (w_sec_idx),
    .o_rdata_a (w_rd_top),
    .o_rdata_b (w_rd_sec)
  );

  // Next-state, stack update and error decisions for the accepted command.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_we0       = 1'b0;
    w_addr0     = w_new_idx;
    w_data0     = entrada;
    w_we1       = 1'b0;
    w_addr1     = w_sec_idx;
    w_data1     = w_rd_top;
    w_err_set   = 1'b0;
    w_err_code  = ERR_OVF;
    w_clear     = 1'b0;
    w_load_op   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_t'(cmd))
            CMD_PUSH: begin
              if (w_full) begin
                w_err_set  = 1'b1;
                w_err_code = ERR_OVF;
              end else begin
                w_we0       = 1'b1;
                w_count_nxt = r_count + CW'(1);
              end
            end
            CMD_POP: begin
              if (w_empty) begin
                w_err_set  = 1'b1;
                w_err_code = ERR_UNF;
              end else begin
                w_count_nxt = r_count - CW'(1);
              end
            end
            CMD_EXEC: begin
              if (w_has2) begin
                w_load_op   = 1'b1;
                w_state_nxt = ST_EXEC;
              end else begin
                w_err_set  = 1'b1;
                w_err_code = ERR_UNF;
              end
            end
            CMD_DUP: begin
              if (w_empty) begin
                w_err_set  = 1'b1;
                w_err_code = ERR_UNF;
              end else if (w_full) begin
                w_err_set  = 1'b1;
                w_err_code = ERR_OVF;
              end else begin
                w_we0       = 1'b1;
                w_data0     = w_rd_top;
                w_count_nxt = r_count + CW'(1);
              end
            end
            CMD_SWAP: begin
              if (!w_has2) begin
                w_err_set  = 1'b1;
                w_err_code = ERR_UNF;
              end else begin
                w_we0   = 1'b1;
                w_addr0 = w_top_idx;
                w_data0 = w_rd_sec;
                w_we1   = 1'b1;
                w_addr1 = w_sec_idx;
                w_data1 = w_rd_top;
              end
            end
            CMD_CLEAR: begin
              w_clear     = 1'b1;
              w_count_nxt = '0;
            end
            CMD_ILL: begin
              w_err_set  = 1'b1;
              w_err_code = ERR_ILL;
            end
            default: begin
            end
          endcase
        end
      end
      ST_EXEC: begin
        // Operands stay untouched during this cycle, so alu_a/alu_b hold.
        // The result overwrites the second word, which becomes the new top.
        w_state_nxt = ST_IDLE;
        if (rst) begin
          if (alu_erro) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_ALU;
          end else begin
            w_we0       = 1'b1;
            w_addr0     = w_sec_idx;
            w_data0     = alu_result;
            w_count_nxt = r_count - CW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Word count, latched ALU opcode and sticky first-error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count    <= '0;
      r_alu_op   <= '0;
      r_erro     <= 1'b0;
      r_erro_cod <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_load_op) r_alu_op <= operacao;
      if (w_clear) begin
        r_erro     <= 1'b0;
        r_erro_cod <= '0;
      end else if (w_err_set && !r_erro) begin
        r_erro     <= 1'b1;
        r_erro_cod <= w_err_code;
      end
    end
  end

  assign w_disp_a = w_empty ? '0 : w_rd_top;
  assign w_disp_b = w_has2  ? w_rd_sec : '0;

  assign cmd_ready   = (r_state == ST_IDLE);
  assign display_a   = w_disp_a;
  assign display_b   = w_disp_b;
  assign alu_a       = w_disp_a;
  assign alu_b       = w_disp_b;
  assign alu_op      = r_alu_op;
  assign contagem    = r_count;
  assign pilha_vazia = w_empty;
  assign pilha_cheia = w_full;
  assign erro        = r_erro;
  assign erro_cod    = r_erro_cod;

endmodule

// File: tb/tb_pilha_rpn_param.sv
// Self-checking bench for pilha_rpn_param (WIDTH=8, DEPTH=4) against a
// queue-based stack model.
module tb_pilha_rpn_param;

  localparam int W = 8;
  localparam int D = 4;

  localparam logic [2:0] C_NOP = 3'd0, C_PUSH = 3'd1, C_POP = 3'd2, C_EXEC = 3'd3,
                         C_DUP = 3'd4, C_SWAP = 3'd5, C_CLR  = 3'd6, C_ILL  = 3'd7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd = '0;
  logic [W-1:0] entrada = '0;
  logic [2:0]   operacao = '0;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result = '0;
  logic         alu_erro = 1'b0;
  logic [W-1:0] display_a, display_b;
  logic [2:0]   contagem;
  logic         pilha_vazia, pilha_cheia, erro;
  logic [1:0]   erro_cod;

  pilha_rpn_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .entrada(entrada), .operacao(operacao), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .alu_erro(alu_erro),
    .display_a(display_a), .display_b(display_b), .contagem(contagem),
    .pilha_vazia(pilha_vazia), .pilha_cheia(pilha_cheia), .erro(erro),
    .erro_cod(erro_cod)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: stack as a queue, top at the back.
  logic [W-1:0] q[$];
  bit           m_erro;
  logic [1:0]   m_cod;
  logic [2:0]   m_op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_erro = 0;
    m_cod  = 2'd0;
    m_op   = 3'd0;
  endtask

  task automatic m_err(input logic [1:0] code);
    if (!m_erro) begin
      m_erro = 1;
      m_cod  = code;
    end
  endtask

  task automatic check_all(input bit in_exec);
    logic [W-1:0] ea, eb;
    int n;
    n  = q.size();
    ea = (n > 0) ? q[n-1] : '0;
    eb = (n > 1) ? q[n-2] : '0;
    chk("display_a", display_a, ea);
    chk("display_b", display_b, eb);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("contagem", contagem, n);
    chk("pilha_vazia", pilha_vazia, n == 0);
    chk("pilha_cheia", pilha_cheia, n == D);
    chk("erro", erro, m_erro);
    chk("erro_cod", erro_cod, m_cod);
    chk("cmd_ready", cmd_ready, !in_exec);
    chk("alu_op", alu_op, m_op);
  endtask

  // Reset for one edge while a command is offered; it must be ignored.
  task automatic do_reset();
    rst = 0; cmd_valid = 1; cmd = C_PUSH; entrada = $urandom;
    @(posedge clk); #1;
    rst = 1; cmd_valid = 0;
    m_reset();
    check_all(0);
  endtask

  // Offer one command; if it starts an ALU operation, also run the EXEC cycle.
  task automatic step(input bit v, input logic [2:0] c, input logic [W-1:0] d,
                      input logic [2:0] op, input logic [W-1:0] res,
                      input bit aerr, input bit rst_exec);
    bit ex;
    logic [W-1:0] t;
    int n;
    ex = 0;
    cmd_valid = v; cmd = c; entrada = d; operacao = op;
    @(posedge clk); #1;
    cmd_valid = 0; cmd = $urandom; entrada = $urandom; operacao = $urandom;
    n = q.size();
    if (v) begin
      case (c)
        C_PUSH: if (n == D) m_err(2'd0); else q.push_back(d);
        C_POP:  if (n == 0) m_err(2'd1); else void'(q.pop_back());
        C_EXEC: if (n < 2) m_err(2'd1); else begin ex = 1; m_op = op; end
        C_DUP:  if (n == 0) m_err(2'd1); else if (n == D) m_err(2'd0); else q.push_back(q[n-1]);
        C_SWAP: if (n < 2) m_err(2'd1); else begin t = q[n-1]; q[n-1] = q[n-2]; q[n-2] = t; end
        C_CLR:  begin q.delete(); m_erro = 0; m_cod = 2'd0; end
        C_ILL:  m_err(2'd3);
        default: ;
      endcase
    end
    check_all(ex);
    if (ex) begin
      alu_result = res; alu_erro = aerr;
      cmd_valid = 1; cmd = $urandom; entrada = $urandom;
      if (rst_exec) rst = 0;
      @(posedge clk); #1;
      cmd_valid = 0; alu_erro = 0; alu_result = $urandom;
      if (rst_exec) begin
        rst = 1;
        m_reset();
      end else if (aerr) begin
        m_err(2'd2);
      end else begin
        void'(q.pop_back());
        void'(q.pop_back());
        q.push_back(res);
      end
      check_all(0);
    end
  endtask

  task automatic simple(input logic [2:0] c, input logic [W-1:0] d);
    step(1, c, d, 3'd0, '0, 0, 0);
  endtask

  initial begin
    int r;
    m_reset();
    @(posedge clk); #1;
    rst = 1;
    check_all(0);

    // Push/push/add writes the result back as the only word.
    do_reset();
    simple(C_PUSH, 8'd5);
    simple(C_PUSH, 8'd3);
    step(1, C_EXEC, '0, 3'd0, 8'd8, 0, 0);
    chk("r028_cnt", contagem, 1);
    chk("r028_a", display_a, 8);

    // Overflow on a full stack.
    do_reset();
    for (int i = 1; i <= 4; i++) simple(C_PUSH, 8'(i));
    simple(C_PUSH, 8'd9);
    chk("r029_cheia", pilha_cheia, 1);
    chk("r029_a", display_a, 4);
    chk("r029_cod", erro_cod, 0);

    // First error (underflow) is held against a later one.
    do_reset();
    simple(C_POP, '0);
    simple(C_PUSH, 8'd7);
    simple(C_EXEC, '0);
    chk("r030_cod", erro_cod, 1);
    chk("r030_a", display_a, 7);

    // SWAP then DUP, then POP.
    do_reset();
    simple(C_PUSH, 8'd10);
    simple(C_PUSH, 8'd20);
    simple(C_SWAP, '0);
    simple(C_DUP, '0);
    chk("r031_a", display_a, 10);
    chk("r031_b", display_b, 10);
    simple(C_POP, '0);
    chk("r031_b2", display_b, 20);

    // ALU error leaves the stack; CLEAR empties and clears the flag.
    do_reset();
    simple(C_PUSH, 8'd2);
    simple(C_PUSH, 8'd0);
    step(1, C_EXEC, '0, 3'd2, 8'hAA, 1, 0);
    chk("r032_cod", erro_cod, 2);
    chk("r032_b", display_b, 2);
    simple(C_CLR, '0);
    chk("r032_erro", erro, 0);
    chk("r032_vazia", pilha_vazia, 1);

    // Reset during the EXEC cycle aborts; illegal code afterwards.
    do_reset();
    simple(C_PUSH, 8'd1);
    simple(C_PUSH, 8'd2);
    step(1, C_EXEC, '0, 3'd5, 8'd3, 0, 1);
    chk("r033_cnt", contagem, 0);
    simple(C_ILL, '0);
    chk("r033_cod", erro_cod, 3);

    // Randomized command mix.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      step(1, C_PUSH, 8'($urandom), 3'd0, '0, 0, 0);
      else if (r < 42) step(1, C_POP, 8'($urandom), 3'd0, '0, 0, 0);
      else if (r < 62) step(1, C_EXEC, 8'($urandom), 3'($urandom), 8'($urandom),
                            ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
      else if (r < 72) step(1, C_DUP, 8'($urandom), 3'd0, '0, 0, 0);
      else if (r < 82) step(1, C_SWAP, 8'($urandom), 3'd0, '0, 0, 0);
      else if (r < 86) step(1, C_CLR, 8'($urandom), 3'd0, '0, 0, 0);
      else if (r < 90) step(1, C_ILL, 8'($urandom), 3'd0, '0, 0, 0);
      else if (r < 93) step(1, C_NOP, 8'($urandom), 3'd0, '0, 0, 0);
      else if (r < 98) step(0, 3'($urandom), 8'($urandom), 3'($urandom), '0, 0, 0);
      else             do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
